ts_stream_failover_ctrl: RTL and testbench

- Packet-aligned selection controller for the 4-stream MPEG2-TS output path.
- Tracks 188-byte sync lock on each of the four input byte streams.
- Chooses which stream feeds the output (requested stream, or automatic failover to a locked one) and drives mux_ctrl.
- Switches only on a sync byte of the new stream and emits the selected stream as the {valid, sync, data} 10-bit word used by the output stage.

---
 rtl/ts_stream_failover_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ts_stream_failover_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts_stream_failover_ctrl.sv
// Packet-aligned 4-stream MPEG2-TS sync tracker and failover selector.
// Optional TS_SWITCH_HOLDOFF_EN enforces a minimum dwell after each switch.
module ts_stream_failover_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    PKT_LEN      = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'h47,
  parameter int                    LOCK_CNT     = 3,
  parameter int                    UNLOCK_CNT   = 2,
  parameter int                    HOLDOFF_PKTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_s1,
  input  logic [DATA_WIDTH-1:0] data_s2,
  input  logic [DATA_WIDTH-1:0] data_s3,
  input  logic [DATA_WIDTH-1:0] data_s4,
  input  logic [3:0]            valid_in,
  input  logic [1:0]            sel_req,
  input  logic                  auto_en,
  output logic [1:0]            mux_ctrl,
  output logic [3:0]            lock,
  output logic                  no_lock,
  output logic                  switch_pulse,
  output logic [DATA_WIDTH+1:0] data_out_final
);

  localparam int PW = $clog2(PKT_LEN);
  localparam int CW = 4;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t                r_state     [4];
  state_t                w_stateNext [4];
  logic [PW-1:0]         r_pos       [4];
  logic [PW-1:0]         w_posNext   [4];
  logic [PW-1:0]         w_posInc    [4];
  logic [CW-1:0]         r_good      [4];
  logic [CW-1:0]         w_goodNext  [4];
  logic [CW-1:0]         r_miss      [4];
  logic [CW-1:0]         w_missNext  [4];
  logic [DATA_WIDTH-1:0] w_data      [4];
  logic [3:0]            w_isSync;
  logic [3:0]            r_lock;
  logic [1:0]            r_mux;
  logic [1:0]            w_target;
  logic [1:0]            w_sel;
  logic                  w_doSwitch;
  logic                  w_holdOk;
  logic                  r_switchPulse;
  logic [DATA_WIDTH+1:0] r_dout;

  assign w_data[0] = data_s1;
  assign w_data[1] = data_s2;
  assign w_data[2] = data_s3;
  assign w_data[3] = data_s4;

  for (genvar g = 0; g < 4; g++) begin : g_stream
    assign w_isSync[g] = (w_data[g] == SYNC_BYTE);
    assign w_posInc[g] = (r_pos[g] == PW'(PKT_LEN - 1)) ? '0 : r_pos[g] + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= HUNT;
        r_pos[i]   <= '0;
        r_good[i]  <= '0;
        r_miss[i]  <= '0;
      end
      r_lock <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_stateNext[i];
        r_pos[i]   <= w_posNext[i];
        r_good[i]  <= w_goodNext[i];
        r_miss[i]  <= w_missNext[i];
        r_lock[i]  <= (w_stateNext[i] == LOCKED);
      end
    end
  end

  // Only valid bytes move the lock machines; pos==0 marks the expected sync slot.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_stateNext[i] = r_state[i];
      w_posNext[i]   = r_pos[i];
      w_goodNext[i]  = r_good[i];
      w_missNext[i]  = r_miss[i];
      if (valid_in[i]) begin
        unique case (r_state[i])
          HUNT: begin
            if (w_isSync[i]) begin
              w_stateNext[i] = VERIFY;
              w_posNext[i]   = PW'(1);
              w_goodNext[i]  = CW'(1);
            end
          end
          VERIFY: begin
            w_posNext[i] = w_posInc[i];
            if (r_pos[i] == '0) begin
              if (w_isSync[i]) begin
                w_goodNext[i] = r_good[i] + CW'(1);
                if (r_good[i] + CW'(1) == CW'(LOCK_CNT)) begin
                  w_stateNext[i] = LOCKED;
                  w_missNext[i]  = '0;
                end
              end else begin
                w_stateNext[i] = HUNT;
                w_goodNext[i]  = '0;
                w_posNext[i]   = '0;
              end
            end
          end
          LOCKED: begin
            w_posNext[i] = w_posInc[i];
            if (r_pos[i] == '0) begin
              if (w_isSync[i]) begin
                w_missNext[i] = '0;
              end else if (r_miss[i] + CW'(1) == CW'(UNLOCK_CNT)) begin
                w_stateNext[i] = HUNT;
                w_posNext[i]   = '0;
                w_goodNext[i]  = '0;
                w_missNext[i]  = '0;
              end else begin
                w_missNext[i] = r_miss[i] + CW'(1);
              end
            end
          end
          default: w_stateNext[i] = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    w_target = r_mux;
    if (r_lock[sel_req]) begin
      w_target = sel_req;
    end else if (auto_en && (r_lock != 4'b0000)) begin
      if (r_lock[0])      w_target = 2'd0;
      else if (r_lock[1]) w_target = 2'd1;
      else if (r_lock[2]) w_target = 2'd2;
      else                w_target = 2'd3;
    end
  end

`ifdef TS_SWITCH_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_PKTS + 1);
  logic [HW-1:0] r_holdoff;

  // An unlocked active stream must not be pinned by the dwell timer.
  assign w_holdOk = (r_holdoff == '0) || !r_lock[r_mux];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdoff <= '0;
    end else if (w_doSwitch) begin
      r_holdoff <= HW'(HOLDOFF_PKTS);
    end else if ((r_holdoff != '0) && valid_in[r_mux] && (r_pos[r_mux] == '0)) begin
      r_holdoff <= r_holdoff - HW'(1);
    end
  end
`else
  logic w_unusedHoldoff;
  assign w_unusedHoldoff = ^HOLDOFF_PKTS;
  assign w_holdOk        = 1'b1;
`endif

  assign w_doSwitch = (w_target != r_mux) && valid_in[w_target] && (r_pos[w_target] == '0)
                    && w_isSync[w_target] && r_lock[w_target] && w_holdOk;
  assign w_sel      = w_doSwitch ? w_target : r_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mux         <= 2'd0;
      r_switchPulse <= 1'b0;
      r_dout        <= '0;
    end else begin
      r_mux         <= w_sel;
      r_switchPulse <= w_doSwitch;
      r_dout        <= {valid_in[w_sel], valid_in[w_sel] & w_isSync[w_sel],
                        valid_in[w_sel] ? w_data[w_sel] : r_dout[DATA_WIDTH-1:0]};
    end
  end

  assign mux_ctrl       = r_mux;
  assign lock           = r_lock;
  assign no_lock        = (r_lock == 4'b0000);
  assign switch_pulse   = r_switchPulse;
  assign data_out_final = r_dout;

endmodule

// File: tb/tb_ts_stream_failover_ctrl.sv
// Directed bench for ts_stream_failover_ctrl: lock/unlock, manual switch,
// auto failover and asynchronous reset, using per-stream packet generators.
module tb_ts_stream_failover_ctrl;

  localparam int PKT = 188;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_s1, data_s2, data_s3, data_s4;
  logic [3:0] valid_in;
  logic [1:0] sel_req;
  logic       auto_en;
  logic [1:0] mux_ctrl;
  logic [3:0] lock;
  logic       no_lock;
  logic       switch_pulse;
  logic [9:0] data_out_final;

  int         checks = 0;
  int         errors = 0;
  int         tbPos [4];
  int         tbBad [4];
  logic [3:0] tbEn;
  logic [7:0] tbData [4];

  ts_stream_failover_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .data_s1        (data_s1),
    .data_s2        (data_s2),
    .data_s3        (data_s3),
    .data_s4        (data_s4),
    .valid_in       (valid_in),
    .sel_req        (sel_req),
    .auto_en        (auto_en),
    .mux_ctrl       (mux_ctrl),
    .lock           (lock),
    .no_lock        (no_lock),
    .switch_pulse   (switch_pulse),
    .data_out_final (data_out_final)
  );

  always #5 clk = ~clk;

  // Payload bytes span 0x10..0x3F so they can never be mistaken for 0x47.
  function automatic logic [7:0] filler(input int p);
    return 8'(8'h10 + (p % 48));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one byte per enabled stream, then samples just after the edge.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (tbPos[i] == 0) tbData[i] = (tbBad[i] > 0) ? 8'h00 : 8'h47;
      else               tbData[i] = filler(tbPos[i]);
    end
    data_s1  = tbData[0];
    data_s2  = tbData[1];
    data_s3  = tbData[2];
    data_s4  = tbData[3];
    valid_in = tbEn;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (tbEn[i]) begin
        if (tbPos[i] == 0 && tbBad[i] > 0) tbBad[i]--;
        tbPos[i] = (tbPos[i] + 1) % PKT;
      end
    end
  endtask

  task automatic toSync(input int s);
    int n = 0;
    while (tbPos[s] != 0 && n < 200) begin
      applyStimulus();
      n++;
    end
    if (tbPos[s] != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL syncBound: stream %0d pos %0d required 0", s, tbPos[s]);
    end
  endtask

  task automatic syncTick(input int s);
    toSync(s);
    applyStimulus();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    rst      = 1'b1;
    sel_req  = 2'd0;
    auto_en  = 1'b0;
    valid_in = 4'b0000;
    data_s1  = 8'h00;
    data_s2  = 8'h00;
    data_s3  = 8'h00;
    data_s4  = 8'h00;
    tbEn     = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tbPos[i] = 0;
      tbBad[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstMux", 32'(mux_ctrl), 32'd0);
    checkOutput("rstLock", 32'(lock), 32'h0);
    checkOutput("rstNoLock", 32'(no_lock), 32'd1);
    checkOutput("rstPulse", 32'(switch_pulse), 32'd0);
    checkOutput("rstDout", 32'(data_out_final), 32'h0);
    rst = 1'b0;

    // Stream 1 locks on its third sync (byte 376).
    applyStimulus();
    checkOutput("firstSyncDout", 32'(data_out_final), 32'h347);
    checkOutput("firstSyncLock", 32'(lock), 32'h0);
    repeat (375) applyStimulus();
    checkOutput("byte375Dout", 32'(data_out_final), 32'h23B);
    checkOutput("byte375Lock", 32'(lock), 32'h0);
    checkOutput("byte375NoLock", 32'(no_lock), 32'd1);
    applyStimulus();
    checkOutput("byte376Lock", 32'(lock), 32'h1);
    checkOutput("byte376NoLock", 32'(no_lock), 32'd0);
    checkOutput("byte376Mux", 32'(mux_ctrl), 32'd0);

    tbEn[0] = 1'b0;
    applyStimulus();
    checkOutput("invalidDout", 32'(data_out_final), 32'h047);
    checkOutput("invalidLock", 32'(lock), 32'h1);
    tbEn[0] = 1'b1;

    // Miss handling: bad, good, bad keeps lock; a second consecutive bad drops it.
    tbBad[0] = 1;
    syncTick(0);
    checkOutput("miss1Lock", 32'(lock), 32'h1);
    checkOutput("miss1Dout", 32'(data_out_final), 32'h200);
    syncTick(0);
    checkOutput("recoverLock", 32'(lock), 32'h1);
    tbBad[0] = 1;
    syncTick(0);
    checkOutput("missAgainLock", 32'(lock), 32'h1);
    tbBad[0] = 1;
    syncTick(0);
    checkOutput("miss2Lock", 32'(lock), 32'h0);
    checkOutput("miss2NoLock", 32'(no_lock), 32'd1);

    // Bring all four streams up, staggered 20/50/100 bytes behind stream 1.
    p0       = tbPos[0];
    tbPos[1] = (p0 + PKT - 20) % PKT;
    tbPos[2] = (p0 + PKT - 50) % PKT;
    tbPos[3] = (p0 + PKT - 100) % PKT;
    tbEn     = 4'b1111;
    repeat (4 * PKT) applyStimulus();
    checkOutput("allLock", 32'(lock), 32'hF);
    checkOutput("allLockMux", 32'(mux_ctrl), 32'd0);

    sel_req = 2'd2;
    toSync(2);
    checkOutput("preSwitchMux", 32'(mux_ctrl), 32'd0);
    applyStimulus();
    checkOutput("switchMux", 32'(mux_ctrl), 32'd2);
    checkOutput("switchPulse", 32'(switch_pulse), 32'd1);
    checkOutput("switchDout", 32'(data_out_final), 32'h347);
    applyStimulus();
    checkOutput("postSwitchPulse", 32'(switch_pulse), 32'd0);
    checkOutput("postSwitchMux", 32'(mux_ctrl), 32'd2);
    checkOutput("postSwitchDout", 32'(data_out_final), 32'h211);

    // Back to stream 1, then knock it out with and without failover.
    sel_req = 2'd0;
    syncTick(0);
    checkOutput("backMux", 32'(mux_ctrl), 32'd0);
    tbBad[0] = 2;
    syncTick(0);
    syncTick(0);
    checkOutput("s1DropLock", 32'(lock), 32'hE);
    repeat (200) applyStimulus();
    checkOutput("manualHoldMux", 32'(mux_ctrl), 32'd0);
    auto_en = 1'b1;
    toSync(1);
    checkOutput("preFailoverMux", 32'(mux_ctrl), 32'd0);
    applyStimulus();
    checkOutput("failoverMux", 32'(mux_ctrl), 32'd1);
    checkOutput("failoverPulse", 32'(switch_pulse), 32'd1);
    checkOutput("failoverDout", 32'(data_out_final), 32'h347);

    // Asynchronous reset mid-packet, checked before the next clock edge.
    auto_en = 1'b0;
    repeat (30) applyStimulus();
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRstMux", 32'(mux_ctrl), 32'd0);
    checkOutput("asyncRstLock", 32'(lock), 32'h0);
    checkOutput("asyncRstNoLock", 32'(no_lock), 32'd1);
    checkOutput("asyncRstPulse", 32'(switch_pulse), 32'd0);
    checkOutput("asyncRstDout", 32'(data_out_final), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    syncTick(0);
    checkOutput("relockSync1", 32'(lock[0]), 32'd0);
    syncTick(0);
    checkOutput("relockSync2", 32'(lock[0]), 32'd0);
    syncTick(0);
    checkOutput("relockSync3", 32'(lock[0]), 32'd1);
    checkOutput("relockMux", 32'(mux_ctrl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
